// File: rtl/i2c_defs_pkg.sv
// Shared I2C target definitions: FSM states, R/W and ACK bit encodings.
package i2c_defs;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_IGNORE,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_LOAD,
    ST_RD_BYTE,
    ST_RD_ACK
  } i2c_state_t;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;

  // A transaction is "ours" once the address phase starts and until we drop off the bus.
  function automatic logic state_is_busy(input i2c_state_t s);
    return !((s == ST_IDLE) || (s == ST_IGNORE));
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer with edge, START and STOP detection on the synchronized lines.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl_in,
  input  logic i_sda_in,
  output logic o_scl,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [SYNC_STAGES-1:0] scl_sync_reg;
  logic [SYNC_STAGES-1:0] sda_sync_reg;
  logic [SYNC_STAGES-1:0] scl_sync_next;
  logic [SYNC_STAGES-1:0] sda_sync_next;
  logic                   scl_prev_reg;
  logic                   sda_prev_reg;

  // Stage 0 takes the raw pin, every later stage takes its predecessor.
  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign scl_sync_next[gi] = i_scl_in;
        assign sda_sync_next[gi] = i_sda_in;
      end else begin : g_chain
        assign scl_sync_next[gi] = scl_sync_reg[gi-1];
        assign sda_sync_next[gi] = sda_sync_reg[gi-1];
      end
    end
  endgenerate

  // Reset to the idle-bus level (both lines high) so reset release never looks like an edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      scl_sync_reg <= '1;
      sda_sync_reg <= '1;
      scl_prev_reg <= 1'b1;
      sda_prev_reg <= 1'b1;
    end else begin
      scl_sync_reg <= scl_sync_next;
      sda_sync_reg <= sda_sync_next;
      scl_prev_reg <= scl_sync_reg[SYNC_STAGES-1];
      sda_prev_reg <= sda_sync_reg[SYNC_STAGES-1];
    end
  end

  assign o_scl      = scl_sync_reg[SYNC_STAGES-1];
  assign o_sda      = sda_sync_reg[SYNC_STAGES-1];
  assign o_scl_rise = o_scl & ~scl_prev_reg;
  assign o_scl_fall = ~o_scl & scl_prev_reg;
  // SDA transitions only count as conditions while SCL is steadily high.
  assign o_start    = o_scl & scl_prev_reg & sda_prev_reg & ~o_sda;
  assign o_stop     = o_scl & scl_prev_reg & ~sda_prev_reg & o_sda;

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, write bytes to an rx holding register, read bytes from a tx stream.
module i2c_target
  import i2c_defs::*;
#(
  parameter logic [6:0]  TARGET_ADDR = 7'h48,
  parameter int          DATA_DEPTH  = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_FILL   = 8'hFF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_scl_in,
  input  logic                  i_sda_in,
  output logic                  o_sda_oe,
  output logic [DATA_DEPTH-1:0] o_rx_bits,
  output logic                  o_rx_valid,
  input  logic                  i_rx_ready,
  input  logic [DATA_DEPTH-1:0] i_tx_bits,
  input  logic                  i_tx_valid,
  output logic                  o_tx_ready,
  output logic                  o_busy,
  output logic                  o_overrun,
  output logic                  o_underrun
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_DEPTH - 1);

  logic line_scl, line_sda, scl_rise, scl_fall, line_start, line_stop;
  logic sample_en;

  i2c_state_t            state_reg;
  logic [3:0]            bit_cnt_reg;
  logic [DATA_DEPTH-1:0] shift_reg;
  logic                  rw_reg;
  logic                  ack_reg;
  logic                  phase_reg;
  logic                  oe_reg;
  logic [DATA_DEPTH-1:0] rx_bits_reg;
  logic                  rx_valid_reg;
  logic                  tx_ready_reg;
  logic                  overrun_reg;
  logic                  underrun_reg;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_scl_in   (i_scl_in),
    .i_sda_in   (i_sda_in),
    .o_scl      (line_scl),
    .o_sda      (line_sda),
    .o_scl_rise (scl_rise),
    .o_scl_fall (scl_fall),
    .o_start    (line_start),
    .o_stop     (line_stop)
  );

  // SDA is read at the SCL rising edge, i.e. with SCL known high.
  assign sample_en = scl_rise & line_scl;

  // Protocol FSM; SDA drive only updates the cycle after an SCL fall so it never moves while SCL is high.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg    <= ST_IDLE;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      rw_reg       <= I2C_RW_WRITE;
      ack_reg      <= 1'b0;
      phase_reg    <= 1'b0;
      oe_reg       <= 1'b0;
      rx_bits_reg  <= '0;
      rx_valid_reg <= 1'b0;
      tx_ready_reg <= 1'b0;
      overrun_reg  <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      tx_ready_reg <= 1'b0;
      overrun_reg  <= 1'b0;
      underrun_reg <= 1'b0;
      // Holding register drains independently of bus activity, and survives STOP.
      if (rx_valid_reg && i_rx_ready) rx_valid_reg <= 1'b0;

      if (line_stop) begin
        state_reg <= ST_IDLE;
        oe_reg    <= 1'b0;
      end else if (line_start) begin
        state_reg   <= ST_ADDR;
        bit_cnt_reg <= '0;
        oe_reg      <= 1'b0;
      end else begin
        case (state_reg)
          ST_ADDR: begin
            if (sample_en) begin
              shift_reg   <= {shift_reg[DATA_DEPTH-2:0], line_sda};
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
              if (bit_cnt_reg == LAST_BIT) begin
                bit_cnt_reg <= '0;
                phase_reg   <= 1'b0;
                // shift_reg[6:0] holds the first seven bits, the incoming bit is R/W.
                if (shift_reg[6:0] == TARGET_ADDR) begin
                  rw_reg    <= line_sda;
                  state_reg <= ST_ADDR_ACK;
                end else begin
                  state_reg <= ST_IGNORE;
                end
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (!phase_reg) begin
                oe_reg    <= 1'b1;
                phase_reg <= 1'b1;
              end else if (rw_reg == I2C_RW_READ) begin
                // ACK stays driven one more cycle; RD_LOAD replaces it with the first data bit.
                state_reg <= ST_RD_LOAD;
              end else begin
                oe_reg      <= 1'b0;
                bit_cnt_reg <= '0;
                state_reg   <= ST_WR_BYTE;
              end
            end
          end
          ST_WR_BYTE: begin
            if (sample_en) begin
              shift_reg   <= {shift_reg[DATA_DEPTH-2:0], line_sda};
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
              if (bit_cnt_reg == LAST_BIT) begin
                bit_cnt_reg <= '0;
                phase_reg   <= 1'b0;
                state_reg   <= ST_WR_ACK;
                if (!rx_valid_reg) begin
                  rx_bits_reg  <= {shift_reg[DATA_DEPTH-2:0], line_sda};
                  rx_valid_reg <= 1'b1;
                  ack_reg      <= 1'b1;
                end else begin
                  ack_reg     <= 1'b0;
                  overrun_reg <= 1'b1;
                end
              end
            end
          end
          ST_WR_ACK: begin
            if (scl_fall) begin
              if (!phase_reg) begin
                oe_reg    <= ack_reg;
                phase_reg <= 1'b1;
              end else begin
                oe_reg      <= 1'b0;
                bit_cnt_reg <= '0;
                state_reg   <= ST_WR_BYTE;
              end
            end
          end
          ST_RD_LOAD: begin
            if (i_tx_valid) begin
              shift_reg    <= i_tx_bits;
              oe_reg       <= ~i_tx_bits[DATA_DEPTH-1];
              tx_ready_reg <= 1'b1;
            end else begin
              shift_reg    <= IDLE_FILL;
              oe_reg       <= ~IDLE_FILL[DATA_DEPTH-1];
              underrun_reg <= 1'b1;
            end
            bit_cnt_reg <= '0;
            state_reg   <= ST_RD_BYTE;
          end
          ST_RD_BYTE: begin
            if (scl_fall) begin
              if (bit_cnt_reg == LAST_BIT) begin
                oe_reg      <= 1'b0;
                bit_cnt_reg <= '0;
                phase_reg   <= 1'b0;
                state_reg   <= ST_RD_ACK;
              end else begin
                oe_reg      <= ~shift_reg[DATA_DEPTH-2];
                shift_reg   <= {shift_reg[DATA_DEPTH-2:0], 1'b0};
                bit_cnt_reg <= bit_cnt_reg + 4'd1;
              end
            end
          end
          ST_RD_ACK: begin
            if (sample_en) begin
              if (line_sda == I2C_NACK) state_reg <= ST_IGNORE;
              else                      phase_reg <= 1'b1;
            end else if (scl_fall && phase_reg) begin
              state_reg <= ST_RD_LOAD;
            end
          end
          ST_IDLE, ST_IGNORE: begin
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_sda_oe   = oe_reg;
  assign o_rx_bits  = rx_bits_reg;
  assign o_rx_valid = rx_valid_reg;
  assign o_tx_ready = tx_ready_reg;
  assign o_overrun  = overrun_reg;
  assign o_underrun = underrun_reg;
  assign o_busy     = state_is_busy(state_reg);

endmodule
